// File: rtl/pll_dri_reconfig_ctrl_if.sv
`timescale 1ns/1ps
// DRI bus between the reconfiguration sequencer (master) and the PLL CCC block (slave).
// ctrl[10:3] = address, ctrl[2] = 0, ctrl[1] = write strobe, ctrl[0] = read strobe.
interface pll_dri_reconfig_ctrl_if;
  logic [10:0] ctrl;
  logic [32:0] wdata;
  logic [32:0] rdata;
  logic        interrupt;

  modport master (
    output ctrl,
    output wdata,
    input  rdata,
    input  interrupt
  );

  modport slave (
    input  ctrl,
    input  wdata,
    output rdata,
    output interrupt
  );
endinterface

// File: rtl/pll_dri_reconfig_ctrl.sv
`timescale 1ns/1ps
// Run-time PLL retune sequencer: gates OUT0, read-modify-writes DIV0/FB_INT over DRI, pulses
// soft reset, then waits for stable lock. Define PLL_DRI_READBACK_VERIFY_EN for verify reads.
module pll_dri_reconfig_ctrl #(
  parameter logic [7:0]  ADDR_DIV0    = 8'h0B,
  parameter logic [7:0]  ADDR_FB      = 8'h09,
  parameter logic [7:0]  ADDR_SRST    = 8'h00,
  parameter int unsigned ACK_TIMEOUT  = 255,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned LOCK_STABLE  = 64
) (
  input  logic                           i_dri_clk,
  input  logic                           i_dri_arst_n,
  input  logic                           i_req,
  input  logic [6:0]                     i_div0_val_in,
  input  logic [11:0]                    i_fb_int_val_in,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_err,
  output logic [1:0]                     o_err_code,
  input  logic                           i_pll_lock_0,
  output logic                           o_pll_out0_en,
  output logic                           o_fabric_reset_n,
  pll_dri_reconfig_ctrl_if.master        dri
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_GATE, ST_RD_DIV, ST_WR_DIV, ST_RB_DIV, ST_RD_FB, ST_WR_FB, ST_RB_FB,
    ST_SRST_SET, ST_SRST_CLR, ST_WAIT_LOCK, ST_DONE, ST_FAIL
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0, ERR_ACK_TMO = 2'd1, ERR_LOCK_TMO = 2'd2, ERR_VALUE = 2'd3
  } err_e;

  localparam logic [15:0] ACK_TMO  = 16'(ACK_TIMEOUT);
  localparam logic [15:0] LOCK_TMO = 16'(LOCK_TIMEOUT);
  localparam logic [15:0] LOCK_STB = 16'(LOCK_STABLE);

  state_e      r_state, w_state_nxt, w_after_ack;
  err_e        r_err_code, w_err_code_nxt, w_fail_code;
  logic        r_lock_meta, r_lock_sync;
  logic [15:0] r_lock_cnt, w_lock_cnt_nxt;
  logic [15:0] r_tmo, w_tmo_nxt;
  logic [6:0]  r_div0;
  logic [11:0] r_fb;
  logic        w_count_en, w_lock_ok, w_rb_bad, w_entering, w_accept;
  logic        r_busy, r_done, r_err, r_out0_en, r_fabric_reset_n;
  logic        w_busy_nxt, w_fabric_reset_n_nxt;
  logic [10:0] r_ctrl, w_ctrl_nxt;
  logic [32:0] r_wdata, w_wdata_nxt;

  // Lock qualification runs only where a stable lock is meaningful; elsewhere it restarts.
  always_comb begin
    w_count_en     = (r_state == ST_IDLE) || (r_state == ST_WAIT_LOCK) || (r_state == ST_DONE);
    w_lock_cnt_nxt = '0;
    if (w_count_en && r_lock_sync) begin
      w_lock_cnt_nxt = (r_lock_cnt >= LOCK_STB) ? LOCK_STB : r_lock_cnt + 16'd1;
    end
    w_lock_ok = (w_lock_cnt_nxt == LOCK_STB);
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_fail_code = ERR_NONE;
    w_after_ack = r_state;
    w_rb_bad    = 1'b0;

    case (r_state)
      ST_RD_DIV:   w_after_ack = ST_WR_DIV;
`ifdef PLL_DRI_READBACK_VERIFY_EN
      ST_WR_DIV:   w_after_ack = ST_RB_DIV;
      ST_WR_FB:    w_after_ack = ST_RB_FB;
`else
      ST_WR_DIV:   w_after_ack = ST_RD_FB;
      ST_WR_FB:    w_after_ack = ST_SRST_SET;
`endif
      ST_RB_DIV:   w_after_ack = ST_RD_FB;
      ST_RD_FB:    w_after_ack = ST_WR_FB;
      ST_RB_FB:    w_after_ack = ST_SRST_SET;
      ST_SRST_SET: w_after_ack = ST_SRST_CLR;
      ST_SRST_CLR: w_after_ack = ST_WAIT_LOCK;
      default:     w_after_ack = r_state;
    endcase

    if (r_state == ST_RB_DIV) w_rb_bad = (dri.rdata[14:8] != r_div0);
    if (r_state == ST_RB_FB)  w_rb_bad = (dri.rdata[11:0] != r_fb);

    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          if (i_div0_val_in == 7'd0) begin
            w_state_nxt = ST_FAIL;
            w_fail_code = ERR_VALUE;
          end else begin
            w_state_nxt = ST_GATE;
          end
        end
      end
      ST_GATE: w_state_nxt = ST_RD_DIV;
      ST_RD_DIV, ST_WR_DIV, ST_RB_DIV, ST_RD_FB, ST_WR_FB, ST_RB_FB,
      ST_SRST_SET, ST_SRST_CLR: begin
        // An ack arriving in the same cycle the timeout expires still completes the access.
        if (dri.interrupt) begin
          if (w_rb_bad) begin
            w_state_nxt = ST_FAIL;
            w_fail_code = ERR_VALUE;
          end else begin
            w_state_nxt = w_after_ack;
          end
        end else if (r_tmo >= ACK_TMO) begin
          w_state_nxt = ST_FAIL;
          w_fail_code = ERR_ACK_TMO;
        end
      end
      ST_WAIT_LOCK: begin
        if (w_lock_ok) begin
          w_state_nxt = ST_DONE;
        end else if (r_tmo >= LOCK_TMO) begin
          w_state_nxt = ST_FAIL;
          w_fail_code = ERR_LOCK_TMO;
        end
      end
      ST_DONE, ST_FAIL: w_state_nxt = ST_IDLE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so they align with the state change.
  always_comb begin
    w_entering = (w_state_nxt != r_state);
    w_accept   = (r_state == ST_IDLE) && (w_state_nxt == ST_GATE);
    w_tmo_nxt  = w_entering ? 16'd0 : ((r_tmo == 16'hFFFF) ? r_tmo : r_tmo + 16'd1);

    w_busy_nxt = !((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE) ||
                   (w_state_nxt == ST_FAIL));
    w_fabric_reset_n_nxt = (w_state_nxt == ST_IDLE) && w_lock_ok;

    w_err_code_nxt = r_err_code;
    if (w_accept)                  w_err_code_nxt = ERR_NONE;
    if (w_state_nxt == ST_FAIL)    w_err_code_nxt = w_fail_code;

    w_ctrl_nxt  = '0;
    w_wdata_nxt = r_wdata;
    if (w_entering) begin
      case (w_state_nxt)
        ST_RD_DIV, ST_RB_DIV: w_ctrl_nxt = {ADDR_DIV0, 3'b001};
        ST_RD_FB,  ST_RB_FB:  w_ctrl_nxt = {ADDR_FB,   3'b001};
        ST_WR_DIV: begin
          w_ctrl_nxt  = {ADDR_DIV0, 3'b010};
          w_wdata_nxt = {dri.rdata[32:15], r_div0, dri.rdata[7:0]};
        end
        ST_WR_FB: begin
          w_ctrl_nxt  = {ADDR_FB, 3'b010};
          w_wdata_nxt = {dri.rdata[32:12], r_fb};
        end
        ST_SRST_SET: begin
          w_ctrl_nxt  = {ADDR_SRST, 3'b010};
          w_wdata_nxt = 33'd1;
        end
        ST_SRST_CLR: begin
          w_ctrl_nxt  = {ADDR_SRST, 3'b010};
          w_wdata_nxt = 33'd0;
        end
        default: w_ctrl_nxt = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_dri_clk or negedge i_dri_arst_n) begin
    if (!i_dri_arst_n) begin
      r_state          <= ST_IDLE;
      r_err_code       <= ERR_NONE;
      r_lock_meta      <= 1'b0;
      r_lock_sync      <= 1'b0;
      r_lock_cnt       <= '0;
      r_tmo            <= '0;
      r_div0           <= '0;
      r_fb             <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_err            <= 1'b0;
      r_out0_en        <= 1'b1;
      r_fabric_reset_n <= 1'b0;
      r_ctrl           <= '0;
      r_wdata          <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_err_code       <= w_err_code_nxt;
      r_lock_meta      <= i_pll_lock_0;
      r_lock_sync      <= r_lock_meta;
      r_lock_cnt       <= w_lock_cnt_nxt;
      r_tmo            <= w_tmo_nxt;
      if (w_accept) begin
        r_div0 <= i_div0_val_in;
        r_fb   <= i_fb_int_val_in;
      end
      r_busy           <= w_busy_nxt;
      r_done           <= (w_state_nxt == ST_DONE);
      r_err            <= (w_state_nxt == ST_FAIL);
      r_out0_en        <= !w_busy_nxt;
      r_fabric_reset_n <= w_fabric_reset_n_nxt;
      r_ctrl           <= w_ctrl_nxt;
      r_wdata          <= w_wdata_nxt;
    end
  end

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_err            = r_err;
  assign o_err_code       = r_err_code;
  assign o_pll_out0_en    = r_out0_en;
  assign o_fabric_reset_n = r_fabric_reset_n;
  assign dri.ctrl         = r_ctrl;
  assign dri.wdata        = r_wdata;

endmodule

// File: tb/tb_pll_dri_reconfig_ctrl.sv
`timescale 1ns/1ps
// Directed bench for pll_dri_reconfig_ctrl: a DRI responder model checks each access against a
// scoreboard of expected accesses; the main sequence checks handshakes, timeouts and reset.
module tb_pll_dri_reconfig_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        lock = 1'b0;
  logic [6:0]  div0 = '0;
  logic [11:0] fb = '0;
  logic        busy, done, err, out0_en, fab_n;
  logic [1:0]  err_code;

  pll_dri_reconfig_ctrl_if dri();

  pll_dri_reconfig_ctrl dut (
    .i_dri_clk        (clk),
    .i_dri_arst_n     (rst_n),
    .i_req            (req),
    .i_div0_val_in    (div0),
    .i_fb_int_val_in  (fb),
    .o_busy           (busy),
    .o_done           (done),
    .o_err            (err),
    .o_err_code       (err_code),
    .i_pll_lock_0     (lock),
    .o_pll_out0_en    (out0_en),
    .o_fabric_reset_n (fab_n),
    .dri              (dri)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] ctrl;
    logic [32:0] wdata;
    bit          chk_wdata;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          ack_en = 1'b1;
  bit          corrupt_rb = 1'b0;
  bit          corrupt_armed = 1'b0;
  int          ack_cd = 0;
  int          strobe_cnt = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [32:0] pll_regs [logic [7:0]];
  logic [32:0] rd_resp = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] reg_rd(input logic [7:0] a);
    return pll_regs.exists(a) ? pll_regs[a] : 33'h1_FFFF_FFFF;
  endfunction

  task automatic push(input logic [7:0] a, input bit wr, input logic [32:0] wd);
    exp_t e;
    e.ctrl      = {a, 1'b0, wr, !wr};
    e.wdata     = wd;
    e.chk_wdata = wr;
    sb_q.push_back(e);
  endtask

  // Expected full retune sequence derived from the current contents of the PLL register model.
  task automatic push_seq(input logic [6:0] d, input logic [11:0] f);
    logic [32:0] o;
    o = reg_rd(8'h0B);
    push(8'h0B, 1'b0, '0);
    push(8'h0B, 1'b1, {o[32:15], d, o[7:0]});
`ifdef PLL_DRI_READBACK_VERIFY_EN
    push(8'h0B, 1'b0, '0);
`endif
    o = reg_rd(8'h09);
    push(8'h09, 1'b0, '0);
    push(8'h09, 1'b1, {o[32:12], f});
`ifdef PLL_DRI_READBACK_VERIFY_EN
    push(8'h09, 1'b0, '0);
`endif
    push(8'h00, 1'b1, 33'd1);
    push(8'h00, 1'b1, 33'd0);
  endtask

  // DRI responder: compares each strobe with the scoreboard and acks one cycle later.
  initial begin
    exp_t        e;
    logic [7:0]  addr;
    dri.interrupt = 1'b0;
    dri.rdata     = '0;
    forever begin
      @(negedge clk);
      dri.interrupt = 1'b0;
      if (ack_cd > 0) begin
        ack_cd--;
        if (ack_cd == 0) begin
          dri.interrupt = 1'b1;
          dri.rdata     = rd_resp;
        end
      end
      if (dri.ctrl[1] || dri.ctrl[0]) begin
        strobe_cnt++;
        check("sb_expected_access", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("dri_ctrl", dri.ctrl, e.ctrl);
          if (e.chk_wdata) check("dri_wdata", dri.wdata, e.wdata);
        end
        addr = dri.ctrl[10:3];
        if (dri.ctrl[1]) begin
          pll_regs[addr] = dri.wdata;
          if (corrupt_rb && addr == 8'h0B) corrupt_armed = 1'b1;
        end else begin
          rd_resp = reg_rd(addr);
          if (corrupt_armed) rd_resp = rd_resp ^ 33'h100;
        end
        if (ack_en) ack_cd = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue_req(input logic [6:0] d, input logic [11:0] f);
    req  = 1'b1;
    div0 = d;
    fb   = f;
    @(negedge clk);
    req  = 1'b0;
  endtask

  task automatic wait_err(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (err) begin cyc = i; break; end
    end
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (done) begin cyc = i; break; end
    end
  endtask

  task automatic wait_fab(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (fab_n) begin cyc = i; break; end
    end
  endtask

  task automatic wait_drained(input string tag, input int max);
    for (int i = 0; i < max && sb_q.size() != 0; i++) @(negedge clk);
    check(tag, sb_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},     busy,      0);
    check({tag, "_done"},     done,      0);
    check({tag, "_err"},      err,       0);
    check({tag, "_err_code"}, err_code,  0);
    check({tag, "_out0_en"},  out0_en,   1);
    check({tag, "_fab_n"},    fab_n,     0);
    check({tag, "_ctrl"},     dri.ctrl,  0);
    check({tag, "_wdata"},    dri.wdata, 0);
  endtask

  initial begin
    int cyc;
    int base_strobe;
    int base_err;
    int base_done;

    // Reset state
    #1 rst_n = 1'b0;
    #3 check_reset_values("reset");
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    lock  = 1'b1;

    // Lock qualification in IDLE
    step(60);
    check("fab_low_before_qual", fab_n, 0);
    wait_fab(20, cyc);
    check("fab_rise_seen", cyc > 0, 1);
    check("fab_rise_window", (60 + cyc >= 62) && (60 + cyc <= 68), 1);
    check("qual_err_code", err_code, 0);
    check("qual_out0_en", out0_en, 1);

    // Nominal retune: DIV0 = 20, FB = 125 against all-ones register contents
    base_err = err_cnt;
    push(8'h0B, 1'b0, '0);
    push(8'h0B, 1'b1, 33'h1_FFFF_94FF);
`ifdef PLL_DRI_READBACK_VERIFY_EN
    push(8'h0B, 1'b0, '0);
`endif
    push(8'h09, 1'b0, '0);
    push(8'h09, 1'b1, 33'h1_FFFF_F07D);
`ifdef PLL_DRI_READBACK_VERIFY_EN
    push(8'h09, 1'b0, '0);
`endif
    push(8'h00, 1'b1, 33'd1);
    push(8'h00, 1'b1, 33'd0);
    issue_req(7'd20, 12'd125);
    lock = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_out0_gated", out0_en, 0);
    check("accept_fab_low", fab_n, 0);
    wait_drained("nominal_sb_drained", 200);
    step(2);
    base_strobe = strobe_cnt;
    req  = 1'b1;
    div0 = 7'd0;
    step(1);
    req  = 1'b0;
    step(80);
    check("busy_in_wait_lock", busy, 1);
    check("wait_lock_out0_gated", out0_en, 0);
    lock = 1'b1;
    wait_done(300, cyc);
    check("done_seen", cyc > 0, 1);
    check("done_lock_window", (cyc >= 64) && (cyc <= 70), 1);
    check("done_out0_en", out0_en, 1);
    check("done_fab_still_low", fab_n, 0);
    step(1);
    check("after_done_fab_high", fab_n, 1);
    check("done_is_pulse", done, 0);
    check("after_done_busy", busy, 0);
    check("busy_req_no_access", strobe_cnt, base_strobe);
    check("nominal_no_err", err_cnt, base_err);

    // No ack on the first read
    ack_en = 1'b0;
    push(8'h0B, 1'b0, '0);
    issue_req(7'd5, 12'd7);
    wait_err(400, cyc);
    check("ack_tmo_err_seen", cyc > 0, 1);
    check("ack_tmo_window", (cyc >= 250) && (cyc <= 265), 1);
    check("ack_tmo_code", err_code, 1);
    check("ack_tmo_fab_low", fab_n, 0);
    check("ack_tmo_out0_en", out0_en, 1);
    check("ack_tmo_sb_drained", sb_q.size(), 0);
    ack_en = 1'b1;
    step(1);
    check("ack_tmo_err_pulse", err, 0);
    wait_fab(200, cyc);
    check("requal_after_fail", (cyc >= 60), 1);

    // Lock never returns
    base_done = done_cnt;
    lock = 1'b0;
    step(4);
    push_seq(7'd3, 12'd10);
    issue_req(7'd3, 12'd10);
    check("accept_clears_err_code", err_code, 0);
    wait_err(60000, cyc);
    check("lock_tmo_err_seen", cyc > 0, 1);
    check("lock_tmo_window", (cyc >= 50000) && (cyc <= 50100), 1);
    check("lock_tmo_code", err_code, 2);
    check("lock_tmo_fab_low", fab_n, 0);
    check("lock_tmo_sb_drained", sb_q.size(), 0);
    check("lock_tmo_no_done", done_cnt, base_done);
    lock = 1'b1;
    wait_fab(200, cyc);
    check("requal_after_lock_tmo", cyc > 0, 1);

    // Illegal DIV0 = 0: immediate failure, no DRI activity
    base_strobe = strobe_cnt;
    issue_req(7'd0, 12'h123);
    check("div0_zero_err", err, 1);
    check("div0_zero_code", err_code, 3);
    check("div0_zero_ctrl_idle", dri.ctrl, 0);
    check("div0_zero_out0_en", out0_en, 1);
    step(1);
    check("div0_zero_err_pulse", err, 0);
    step(5);
    check("div0_zero_no_access", strobe_cnt, base_strobe);
    check("err_code_held", err_code, 3);
    wait_fab(200, cyc);
    check("requal_after_div0_zero", cyc > 0, 1);

`ifdef PLL_DRI_READBACK_VERIFY_EN
    // Readback returns a different DIV0
    begin
      logic [32:0] o;
      o = reg_rd(8'h0B);
      corrupt_rb = 1'b1;
      push(8'h0B, 1'b0, '0);
      push(8'h0B, 1'b1, {o[32:15], 7'd9, o[7:0]});
      push(8'h0B, 1'b0, '0);
      issue_req(7'd9, 12'h055);
      check("rb_accept_clears_code", err_code, 0);
      wait_err(2000, cyc);
      check("rb_err_seen", cyc > 0, 1);
      check("rb_mismatch_code", err_code, 3);
      check("rb_sb_drained", sb_q.size(), 0);
      corrupt_rb    = 1'b0;
      corrupt_armed = 1'b0;
      wait_fab(200, cyc);
      check("requal_after_rb", cyc > 0, 1);
    end
`endif

    // Reset asserted while waiting for lock
    lock = 1'b0;
    step(4);
    push_seq(7'd17, 12'hABC);
    issue_req(7'd17, 12'hABC);
    wait_drained("rst_seq_sb_drained", 200);
    step(10);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_out0_gated", out0_en, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid_reset");
    step(2);
    rst_n = 1'b1;
    step(3);
    check("post_reset_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_dri_reconfig_ctrl.md
# pll_dri_reconfig_ctrl

Sequencer that retunes the fabric PLL at run time through its Dynamic Reconfiguration Interface (DRI). On a request it gates OUT0 and holds the fabric in reset. It then read-modify-writes the OUT0 divider and feedback integer registers, pulses the PLL soft reset, and waits for a stable lock before releasing. It sits between the fabric PLL (CCC) and the system reset/clock-gating logic, clocked by the PLL's DRI clock.

## Interface
Parameters:
- ADDR_DIV0, 8'h0B: DRI address of the register holding DIV0_VAL in bits [14:8].
- ADDR_FB, 8'h09: DRI address of the register holding FB_INT_VAL in bits [11:0].
- ADDR_SRST, 8'h00: DRI address of the soft-reset register; bit 0 = SOFTRESET.
- ACK_TIMEOUT, 255: maximum cycles to wait for DRI_INTERRUPT per access.
- LOCK_TIMEOUT, 50000: maximum cycles to wait for stable lock.
- LOCK_STABLE, 64: consecutive synchronized lock cycles required to count as locked.

Ports:
- DRI_CLK  in  1  sole clock.
- DRI_ARST_N  in  1  asynchronous active-low reset.
- REQ  in  1  start reconfiguration; sampled only in IDLE.
- DIV0_VAL_IN  in  7  new OUT0 divider, captured with REQ.
- FB_INT_VAL_IN  in  12  new feedback integer, captured with REQ.
- BUSY  out  1  sequence in progress.
- DONE  out  1  one-cycle pulse on successful completion.
- ERR  out  1  one-cycle pulse on failure.
- ERR_CODE  out  2  cause of the last failure, held until the next REQ is accepted: 1 = ack timeout, 2 = lock timeout, 3 = illegal value/readback mismatch.
- PLL_LOCK_0  in  1  asynchronous PLL lock; synchronized with two flops.
- PLL_OUT0_EN  out  1  drives PLL OUT0_EN.
- FABRIC_RESET_N  out  1  active-low reset to logic clocked by OUT0.
- DRI_CTRL  out  11  bits [10:3] = address, [2] = 0, [1] = write strobe, [0] = read strobe.
- DRI_WDATA  out  33  write data.
- DRI_RDATA  in  33  read data, valid in the DRI_INTERRUPT cycle.
- DRI_INTERRUPT  in  1  access acknowledge.

## Operation
- States: IDLE, GATE, RD_DIV, WR_DIV, RD_FB, WR_FB, SRST_SET, SRST_CLR, WAIT_LOCK, DONE, FAIL.
- **IDLE**
  - FABRIC_RESET_N rises after LOCK_STABLE consecutive synchronized lock cycles.
  - It falls immediately if lock drops.
  - REQ with DIV0_VAL_IN == 0 goes to FAIL with code 3 and performs no DRI access.
  - Any other REQ captures the inputs and goes to GATE.
- **GATE**: PLL_OUT0_EN = 0 and FABRIC_RESET_N = 0. Both are held there until DONE or FAIL.
- **Access**
  - Strobe asserted for exactly one cycle with the address; DRI_CTRL then returns to 0.
  - The FSM waits for DRI_INTERRUPT.
  - More than ACK_TIMEOUT cycles with no ack → FAIL, code 1.
  - DRI_INTERRUPT outside a pending access is ignored.
- **RD_DIV / WR_DIV**: read ADDR_DIV0, replace bits [14:8] with the captured DIV0, write back. All other bits are preserved.
- **RD_FB / WR_FB**: same read-modify-write on ADDR_FB, bits [11:0].
- **SRST_SET / SRST_CLR**: write 1, then 0, to ADDR_SRST bit 0; all other bits are 0.
- **WAIT_LOCK**
  - The stability counter clears on any lock low.
  - It reaches LOCK_STABLE → DONE.
  - More than LOCK_TIMEOUT cycles → FAIL, code 2.
- **DONE**
  - DONE pulse; PLL_OUT0_EN = 1.
  - FABRIC_RESET_N = 1 the following cycle.
  - Return to IDLE.
- **FAIL**
  - ERR pulse; PLL_OUT0_EN = 1; FABRIC_RESET_N stays 0.
  - Return to IDLE, which re-qualifies lock normally.
- REQ while BUSY is ignored; no queuing.

## Timing
- Reset values: BUSY 0, DONE 0, ERR 0, ERR_CODE 0, PLL_OUT0_EN 1, FABRIC_RESET_N 0, DRI_CTRL 0, DRI_WDATA 0, all counters 0, state IDLE.
- REQ accepted at edge N → BUSY = 1 and PLL_OUT0_EN = 0 at N+1.
- First read strobe at N+2.
- Minimum sequence length with single-cycle acks is 2 + 6×2 + LOCK_STABLE cycles.
- All outputs are registered.
- Timeout counters are 16 bits and saturate; no wrap.
- The lock counter is 16 bits and saturates at LOCK_STABLE.
- Reset asserted mid-sequence:
  - All outputs return to their reset values immediately (asynchronously).
  - A partially written PLL is not restored.
  - Recovery happens by re-qualifying lock in IDLE.
- Ack and timeout expiring in the same cycle: the ack wins.

## Configuration
- PLL_DRI_READBACK_VERIFY_EN
  - **Defined**: after each of WR_DIV and WR_FB, one extra read of the same address. The written field must match the read value, otherwise FAIL with code 3.
  - **Undefined**: no verify reads; the sequence is two accesses shorter.

## Test plan
- Reset then lock high for 64 cycles → FABRIC_RESET_N rises on cycle 64; ERR_CODE = 0.
- REQ with DIV0 = 7'd20, FB = 12'd125, RDATA = 33'h1_FFFF_FFFF, 1-cycle acks:
  - Write data is 33'h1_FFFF_94FF to address 0x0B, then 33'h1_FFFF_F07D to address 0x09.
  - SRST writes are 1 then 0.
  - Lock after 100 cycles → DONE pulse, PLL_OUT0_EN = 1.
- No ack on RD_DIV → ERR after 255 wait cycles, ERR_CODE = 1, FABRIC_RESET_N = 0.
- Lock never returns → ERR after 50000 cycles, ERR_CODE = 2.
- REQ with DIV0 = 0 → ERR the next cycle, no DRI_CTRL activity; REQ pulses during BUSY have no effect.
- With the macro defined, readback returns a different DIV0 → ERR_CODE = 3.
- Reset asserted mid-WAIT_LOCK → all outputs return to reset values in the same cycle.
